// File: rtl/spmc_config_writer_if.sv
// AXI-stream configuration channel carrying SPM-control register-write packets.
interface spmc_config_writer_if;
    logic [31:0] S_AXIS_CFG_tdata;
    logic        S_AXIS_CFG_tvalid;
    logic        S_AXIS_CFG_tready;
    logic        S_AXIS_CFG_tlast;

    modport master (
        output S_AXIS_CFG_tdata,
        output S_AXIS_CFG_tvalid,
        output S_AXIS_CFG_tlast,
        input  S_AXIS_CFG_tready
    );

    modport slave (
        input  S_AXIS_CFG_tdata,
        input  S_AXIS_CFG_tvalid,
        input  S_AXIS_CFG_tlast,
        output S_AXIS_CFG_tready
    );
endinterface

// File: rtl/spmc_config_writer.sv
// Assembles header+payload config packets into a wide register block and strobes
// the target address for a fixed hold window, one update per packet.
module spmc_config_writer #(
    parameter int unsigned NUM_WORDS   = 16,
    parameter logic [31:0] IDLE_ADDR   = 32'd0,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                      a_clk,
    input  logic                      a_rst,
    spmc_config_writer_if.slave       s_axis_cfg,
    output logic [31:0]               config_addr,
    output logic [NUM_WORDS*32-1:0]   config_data,
    output logic                      cfg_busy,
    output logic                      cfg_error,
    output logic [15:0]               cfg_commit_count
);

    localparam int unsigned DW = NUM_WORDS * 32;
    localparam int unsigned KW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned SW = $clog2(DW);
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_DRAIN
    } state_t;

    state_t          state_q;
    logic [KW-1:0]   k_q;
    logic [15:0]     n_q;
    logic [15:0]     addr_q;
    logic [DW-1:0]   shadow_q;
    logic [HW-1:0]   hold_q;
    logic            drain_q;
    logic            tready_q;

    logic [15:0]     hdr_n;
    logic            hdr_ok;
    logic            accept;
    logic            last_word;
    logic [SW-1:0]   base;
    logic [DW-1:0]   shadow_merged;

    // Header decode and the shadow image including the beat currently on the bus.
    always_comb begin
        hdr_n         = s_axis_cfg.S_AXIS_CFG_tdata[31:16];
        hdr_ok        = (hdr_n != 16'd0) && (hdr_n <= 16'(NUM_WORDS));
        accept        = tready_q && s_axis_cfg.S_AXIS_CFG_tvalid;
        last_word     = ((16'(k_q) + 16'd1) == n_q);
        base          = SW'({k_q, 5'b0});
        shadow_merged = shadow_q;
        shadow_merged[base +: 32] = s_axis_cfg.S_AXIS_CFG_tdata;
    end

    assign s_axis_cfg.S_AXIS_CFG_tready = tready_q;

    always_ff @(posedge a_clk or posedge a_rst) begin
        if (a_rst) begin
            state_q          <= S_IDLE;
            k_q              <= '0;
            n_q              <= '0;
            addr_q           <= '0;
            shadow_q         <= '0;
            hold_q           <= '0;
            drain_q          <= 1'b0;
            tready_q         <= 1'b0;
            config_addr      <= IDLE_ADDR;
            config_data      <= '0;
            cfg_busy         <= 1'b0;
            cfg_error        <= 1'b0;
            cfg_commit_count <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tready_q <= 1'b1;
                    if (accept) begin
                        if (hdr_ok) begin
                            state_q   <= S_LOAD;
                            cfg_busy  <= 1'b1;
                            k_q       <= '0;
                            n_q       <= hdr_n;
                            addr_q    <= s_axis_cfg.S_AXIS_CFG_tdata[15:0];
                            shadow_q  <= '0;
                            cfg_error <= 1'b0;
                        end else begin
                            cfg_error <= 1'b1;
                            // A bad header that also closes the packet has nothing to drain.
                            if (!s_axis_cfg.S_AXIS_CFG_tlast) begin
                                state_q  <= S_DRAIN;
                                cfg_busy <= 1'b1;
                            end
                        end
                    end
                end

                S_LOAD: begin
                    if (accept) begin
                        if (last_word) begin
                            shadow_q    <= shadow_merged;
                            config_data <= shadow_merged;
                            config_addr <= {16'd0, addr_q};
                            hold_q      <= '0;
                            drain_q     <= !s_axis_cfg.S_AXIS_CFG_tlast;
                            tready_q    <= 1'b0;
                            state_q     <= S_COMMIT;
                            if (!s_axis_cfg.S_AXIS_CFG_tlast) begin
                                cfg_error <= 1'b1;
                            end
                        end else if (s_axis_cfg.S_AXIS_CFG_tlast) begin
                            cfg_error <= 1'b1;
                            state_q   <= S_IDLE;
                            cfg_busy  <= 1'b0;
                        end else begin
                            shadow_q <= shadow_merged;
                            k_q      <= k_q + KW'(1);
                        end
                    end
                end

                S_COMMIT: begin
                    if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                        cfg_commit_count <= cfg_commit_count + 16'd1;
                        config_addr      <= IDLE_ADDR;
                        tready_q         <= 1'b1;
                        state_q          <= drain_q ? S_DRAIN : S_IDLE;
                        cfg_busy         <= drain_q;
                        drain_q          <= 1'b0;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end

                S_DRAIN: begin
                    if (accept && s_axis_cfg.S_AXIS_CFG_tlast) begin
                        state_q  <= S_IDLE;
                        cfg_busy <= 1'b0;
                    end
                end

                default: begin
                    state_q  <= S_IDLE;
                    cfg_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spmc_config_writer.sv
// Directed and randomized packet bench for spmc_config_writer with a packet-level reference model.
module tb_spmc_config_writer;

    localparam int HOLD = 4;

    logic         a_clk = 1'b0;
    logic         a_rst;
    logic [31:0]  config_addr;
    logic [511:0] config_data;
    logic         cfg_busy;
    logic         cfg_error;
    logic [15:0]  cfg_commit_count;

    always #5 a_clk = ~a_clk;

    spmc_config_writer_if cfg_if ();

    spmc_config_writer dut (
        .a_clk            (a_clk),
        .a_rst            (a_rst),
        .s_axis_cfg       (cfg_if.slave),
        .config_addr      (config_addr),
        .config_data      (config_data),
        .cfg_busy         (cfg_busy),
        .cfg_error        (cfg_error),
        .cfg_commit_count (cfg_commit_count)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state: last committed block, commit count, error flag.
    logic [511:0] exp_data = '0;
    int           exp_count = 0;
    logic         exp_err = 1'b0;

    logic [31:0]  pw [0:19];
    logic         pl [0:19];

    // Observed address strobes: address, data, strobe length, instability/tready flag.
    logic [31:0]  r_addr [$];
    logic [511:0] r_data [$];
    int           r_len  [$];
    bit           r_bad  [$];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin : monitor
        logic [31:0]  m_addr;
        logic [511:0] m_data;
        int           m_len;
        bit           m_bad;
        m_len = 0;
        m_bad = 0;
        m_addr = '0;
        m_data = '0;
        forever begin
            @(negedge a_clk);
            if (a_rst === 1'b1) begin
                m_len = 0;
            end else if (config_addr !== 32'd0) begin
                if (m_len == 0) begin
                    m_addr = config_addr;
                    m_data = config_data;
                    m_bad  = 0;
                end else if (config_addr !== m_addr || config_data !== m_data) begin
                    m_bad = 1;
                end
                if (cfg_if.S_AXIS_CFG_tready !== 1'b0) m_bad = 1;
                m_len++;
            end else if (m_len != 0) begin
                r_addr.push_back(m_addr);
                r_data.push_back(m_data);
                r_len.push_back(m_len);
                r_bad.push_back(m_bad);
                m_len = 0;
            end
        end
    end

    // One beat, called at a negedge; returns at the negedge right after its handshake.
    task automatic beat(input logic [31:0] d, input logic l, input bit gaps);
        int n;
        if (gaps) begin
            n = int'($urandom_range(0, 2));
            if (n > 0) begin
                cfg_if.S_AXIS_CFG_tvalid = 1'b0;
                repeat (n) @(negedge a_clk);
            end
        end
        cfg_if.S_AXIS_CFG_tdata  = d;
        cfg_if.S_AXIS_CFG_tlast  = l;
        cfg_if.S_AXIS_CFG_tvalid = 1'b1;
        n = 0;
        while (cfg_if.S_AXIS_CFG_tready !== 1'b1 && n < 200) begin
            @(negedge a_clk);
            n++;
        end
        if (n >= 200) check("handshake_timeout", 512'(cfg_if.S_AXIS_CFG_tready), 512'(1'b1));
        else @(negedge a_clk);
    endtask

    task automatic run_packet(input string name, input logic [31:0] hdr, input logic hl,
                              input int nb, input bit gaps);
        int n_w;
        int first_last;
        int q0;
        int w;
        bit commit_exp;
        logic err_exp;
        logic [511:0] d_exp;

        n_w = int'(hdr[31:16]);
        commit_exp = 0;
        err_exp = 1'b1;
        d_exp = '0;
        if (n_w >= 1 && n_w <= 16) begin
            first_last = nb;
            for (int j = nb - 1; j >= 0; j--) if (pl[j]) first_last = j;
            if (first_last >= n_w - 1) begin
                commit_exp = 1;
                err_exp = !pl[n_w - 1];
                for (int i = 0; i < n_w; i++) d_exp = d_exp | (512'(pw[i]) << (32 * i));
            end
        end

        q0 = r_addr.size();
        beat(hdr, hl, gaps);
        for (int j = 0; j < nb; j++) begin
            beat(pw[j], pl[j], gaps);
            if (commit_exp && j == n_w - 1) begin
                check({name, "_strobe_start"}, 512'(config_addr), 512'({16'd0, hdr[15:0]}));
                check({name, "_tready_hold"}, 512'(cfg_if.S_AXIS_CFG_tready), 512'(1'b0));
            end
        end
        cfg_if.S_AXIS_CFG_tvalid = 1'b0;
        cfg_if.S_AXIS_CFG_tlast  = 1'b0;

        w = 0;
        while (cfg_busy !== 1'b0 && w < 200) begin
            @(negedge a_clk);
            w++;
        end
        repeat (2) @(negedge a_clk);

        if (commit_exp) begin
            exp_data  = d_exp;
            exp_count = (exp_count + 1) % 65536;
        end
        exp_err = err_exp;

        check({name, "_strobes"}, 512'(r_addr.size() - q0), 512'(commit_exp ? 1 : 0));
        if (commit_exp && r_addr.size() > q0) begin
            check({name, "_strobe_addr"}, 512'(r_addr[q0]), 512'({16'd0, hdr[15:0]}));
            check({name, "_strobe_data"}, r_data[q0], d_exp);
            check({name, "_strobe_len"}, 512'(r_len[q0]), 512'(HOLD));
            check({name, "_strobe_stable"}, 512'(r_bad[q0]), 512'(1'b0));
        end
        check({name, "_data"}, config_data, exp_data);
        check({name, "_count"}, 512'(cfg_commit_count), 512'(exp_count));
        check({name, "_error"}, 512'(cfg_error), 512'(exp_err));
        check({name, "_busy"}, 512'(cfg_busy), 512'(1'b0));
        check({name, "_addr_idle"}, 512'(config_addr), 512'(0));
    endtask

    initial begin : stimulus
        int q0;
        int nr;
        a_rst = 1'b1;
        cfg_if.S_AXIS_CFG_tdata  = '0;
        cfg_if.S_AXIS_CFG_tvalid = 1'b0;
        cfg_if.S_AXIS_CFG_tlast  = 1'b0;
        repeat (3) @(negedge a_clk);
        check("rst_tready", 512'(cfg_if.S_AXIS_CFG_tready), 512'(1'b0));
        check("rst_addr", 512'(config_addr), 512'(0));
        check("rst_data", config_data, 512'(0));
        check("rst_count", 512'(cfg_commit_count), 512'(0));
        check("rst_busy", 512'(cfg_busy), 512'(1'b0));
        check("rst_error", 512'(cfg_error), 512'(1'b0));
        a_rst = 1'b0;
        @(negedge a_clk);
        check("post_rst_tready", 512'(cfg_if.S_AXIS_CFG_tready), 512'(1'b1));

        pw[0] = 32'h0000_1000; pl[0] = 1'b0;
        pw[1] = 32'h0000_2000; pl[1] = 1'b1;
        run_packet("basic", 32'h0002_044C, 1'b0, 2, 1'b0);

        for (int k = 0; k < 16; k++) begin
            pw[k] = 32'h1111_1111 * k;
            pl[k] = (k == 15);
        end
        run_packet("full16", 32'h0010_044F, 1'b0, 16, 1'b1);

        pw[0] = 32'hDEAD_0001; pl[0] = 1'b0;
        pw[1] = 32'hDEAD_0002; pl[1] = 1'b0;
        pw[2] = 32'hDEAD_0003; pl[2] = 1'b1;
        run_packet("n_zero", 32'h0000_044C, 1'b0, 3, 1'b1);

        pw[0] = 32'hCAFE_F00D; pl[0] = 1'b1;
        run_packet("err_clear", 32'h0001_044D, 1'b0, 1, 1'b0);

        run_packet("n17_tlast", 32'h0011_044E, 1'b1, 0, 1'b0);

        pw[0] = 32'hAAAA_0000; pl[0] = 1'b0;
        pw[1] = 32'hAAAA_0001; pl[1] = 1'b1;
        run_packet("abort", 32'h0004_044E, 1'b0, 2, 1'b1);

        pw[0] = 32'hBBBB_0000; pl[0] = 1'b0;
        pw[1] = 32'hBBBB_0001; pl[1] = 1'b0;
        pw[2] = 32'hBBBB_0002; pl[2] = 1'b0;
        pw[3] = 32'hBBBB_0003; pl[3] = 1'b1;
        run_packet("no_tlast", 32'h0002_044D, 1'b0, 4, 1'b1);

        pw[0] = 32'h1234_5678; pl[0] = 1'b0;
        pw[1] = 32'h9ABC_DEF0; pl[1] = 1'b0;
        pw[2] = 32'h0F0F_0F0F; pl[2] = 1'b1;
        run_packet("after_drain", 32'h0003_044C, 1'b0, 3, 1'b0);

        for (int r = 0; r < 6; r++) begin
            nr = int'($urandom_range(1, 16));
            for (int k = 0; k < nr; k++) begin
                pw[k] = $urandom;
                pl[k] = (k == nr - 1);
            end
            run_packet("random", {16'(nr), 16'($urandom_range(1, 65535))}, 1'b0, nr, 1'b1);
        end

        // Reset asserted during the second hold cycle of a commit.
        beat(32'h0001_044D, 1'b0, 1'b0);
        beat(32'h5555_AAAA, 1'b1, 1'b0);
        cfg_if.S_AXIS_CFG_tvalid = 1'b0;
        cfg_if.S_AXIS_CFG_tlast  = 1'b0;
        @(negedge a_clk);
        check("midrst_pre_addr", 512'(config_addr), 512'(32'd1101));
        q0 = r_addr.size();
        a_rst = 1'b1;
        #1;
        check("midrst_addr", 512'(config_addr), 512'(0));
        check("midrst_data", config_data, 512'(0));
        check("midrst_count", 512'(cfg_commit_count), 512'(0));
        check("midrst_tready", 512'(cfg_if.S_AXIS_CFG_tready), 512'(1'b0));
        check("midrst_busy", 512'(cfg_busy), 512'(1'b0));
        repeat (2) @(negedge a_clk);
        a_rst = 1'b0;
        @(negedge a_clk);
        check("midrst_release_tready", 512'(cfg_if.S_AXIS_CFG_tready), 512'(1'b1));
        repeat (6) @(negedge a_clk);
        check("midrst_no_strobe", 512'(r_addr.size() - q0), 512'(0));
        check("midrst_addr_idle", 512'(config_addr), 512'(0));
        exp_data  = '0;
        exp_count = 0;
        exp_err   = 1'b0;

        pw[0] = 32'h0000_0007; pl[0] = 1'b0;
        pw[1] = 32'h0000_0008; pl[1] = 1'b1;
        run_packet("post_rst", 32'h0002_0450, 1'b0, 2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spmc_config_writer.md
# spmc_config_writer

Transmit side of the SPM-control configuration bus. Accepts 32-bit register-write packets from the PS over an AXI-stream slave and assembles each packet into a 512-bit `config_data` word. It then presents the word together with its `config_addr` for a fixed hold window and returns the address to idle, so downstream blocks decoding `config_addr` (e.g. offset, rotation, slope and modulation registers at 1100..1103) latch exactly one update per packet.

## Interface
Parameters:
- `NUM_WORDS`, 16: payload words per `config_data` (32 bits each, 512 total).
- `IDLE_ADDR`, 0: `config_addr` value outside a commit; must not match any consumer address.
- `HOLD_CYCLES`, 4: cycles the target address is driven per commit (≥1).

Ports:
- `a_clk`  in  1: sole clock. Everything is rising-edge.
- `a_rst`  in  1: reset, asynchronous and active-high.
- `S_AXIS_CFG_tdata`  in  32: header or payload word.
- `S_AXIS_CFG_tvalid`  in  1: beat valid.
- `S_AXIS_CFG_tready`  out  1: beat accepted when high together with tvalid.
- `S_AXIS_CFG_tlast`  in  1: marks the last payload beat.
- `config_addr`  out  32: target register address, or `IDLE_ADDR`.
- `config_data`  out  512: assembled register block.
- `cfg_busy`  out  1: high whenever the state is not IDLE.
- `cfg_error`  out  1: sticky protocol error flag; cleared by the next accepted valid header.
- `cfg_commit_count`  out  16: number of commits, wraps at 65535→0.

## Operation
- Header beat: `tdata[31:16]` = N (word count), `tdata[15:0]` = target address A, zero-extended to 32 bits.
- Payload word k (k = 0..N-1) is written to `shadow[k*32 +: 32]`. On header accept the shadow is cleared to 0, so unwritten words are 0.
- States:
  - IDLE: tready=1. Header accepted:
    - 1≤N≤NUM_WORDS → LOAD, k=0, latch A and N, clear `cfg_error`.
    - N=0 or N>NUM_WORDS → set `cfg_error`. If the header beat has tlast=1, stay IDLE; otherwise go to DRAIN.
    - A header beat with tlast=1 and a valid N is treated as a normal header. tlast on a header is ignored.
  - LOAD: tready=1. Each accepted beat stores word k, then k←k+1.
    - Beat k=N-1 with tlast=1 → COMMIT.
    - Beat k=N-1 with tlast=0 → set `cfg_error`, go to DRAIN, and still commit. The commit runs first (COMMIT then DRAIN).
    - Beat k<N-1 with tlast=1 → set `cfg_error`, abort with no commit, back to IDLE. That word is discarded.
  - COMMIT: tready=0.
    - On entry, `config_data` ← shadow (including the final word) and `config_addr` ← A. Hold both for HOLD_CYCLES cycles.
    - On the last hold cycle `cfg_commit_count` increments. The next cycle drives `config_addr` ← IDLE_ADDR.
    - Exit to IDLE, or to DRAIN if the drain is pending.
  - DRAIN: tready=1. Discard beats until one with tlast=1 is accepted, then go to IDLE.
- `config_data` holds its last committed value indefinitely. It changes only on COMMIT entry.
- No other state updates `config_addr`.

## Timing
- Reset values, applied immediately and asynchronously:
  - `config_addr`=IDLE_ADDR, `config_data`=0, shadow=0
  - state=IDLE, `cfg_busy`=0, `cfg_error`=0, `cfg_commit_count`=0
  - `tready`=0 while `a_rst` is high, then 1 on the first cycle after release.
- Reset mid-packet or mid-commit: the address returns to IDLE_ADDR at once and the partial packet is lost.
- `tready` is a function of registered state only; no combinational path from `tvalid`.
- Latency: last payload beat accepted at edge t → `config_addr`=A and new `config_data` visible after edge t, i.e. during cycles t+1 … t+HOLD_CYCLES. `config_addr`=IDLE_ADDR from cycle t+HOLD_CYCLES+1.
- Next header accepted no earlier than edge t+HOLD_CYCLES+1.
- Throughput: a packet of N words occupies N+1+HOLD_CYCLES cycles with tvalid held high.
- tvalid gaps are allowed anywhere. State and k do not advance without a handshake.

## Test plan
- Header 0x0002_044C (N=2, A=1100), payload 0x0000_1000, 0x0000_2000 with tlast on beat 2:
  - `config_addr`=1100 for exactly 4 cycles starting the cycle after beat 2.
  - `config_data[63:0]`=0x0000_2000_0000_1000, upper bits 0.
  - `cfg_commit_count`=1, then `config_addr`=0.
- Full packet N=16, A=1103, words 0x11111111·k, with random tvalid gaps:
  - All 16 words land in order.
  - tready=0 during the 4 hold cycles.
- Header N=0 with tlast=0, then 3 junk beats (the last with tlast):
  - `cfg_error`=1, no commit, back in IDLE.
  - Next valid header clears `cfg_error`.
- Header N=4, tlast on payload beat 2:
  - No address strobe; `config_data` unchanged from the previous commit.
  - `cfg_error`=1.
- Header N=2, no tlast on beat 2, then 2 extra beats (the last with tlast):
  - Commit occurs with words 0..1 and `cfg_error`=1.
  - The extra beats are drained; the following packet commits normally.
- Assert `a_rst` during the second hold cycle of a commit:
  - `config_addr`=0, `config_data`=0 and `cfg_commit_count`=0 immediately.
  - tready=1 the first cycle after release.
